// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
// Provides the FSM state enum, geometry constants and tag/index slicing.
package cache_pkg;

   localparam int INDEX_W = 4;
   localparam int TAG_W   = 32 - INDEX_W - 2;
   localparam int LINES   = 1 << INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_RD,
      MEM_WR,
      DONE
   } state_t;

   typedef logic [TAG_W-1:0]   tag_t;
   typedef logic [INDEX_W-1:0] idx_t;

   function automatic tag_t addr_tag(input logic [31:0] a);
      return a[31:INDEX_W+2];
   endfunction

   function automatic idx_t addr_idx(input logic [31:0] a);
      return a[INDEX_W+1:2];
   endfunction

   function automatic logic [31:0] mk_addr(input tag_t t,
                                           input idx_t i);
      return {t, i, 2'b00};
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU and memory bus signals of the cache controller.
// slave: controller side; master: CPU/memory side (bench).
interface cache_controller_if;

   logic        iCpuReq;
   logic        iCpuWe;
   logic [31:0] iCpuAddr;
   logic [31:0] iCpuWData;
   logic        iFlush;
   logic [31:0] oCpuRData;
   logic        oCpuReady;
   logic        oBusy;
   logic        oMemReq;
   logic        oMemWe;
   logic [31:0] oMemAddr;
   logic [31:0] oMemWData;
   logic        iMemAck;
   logic [31:0] iMemRData;

   modport slave (
      input  iCpuReq, iCpuWe, iCpuAddr, iCpuWData,
      input  iFlush, iMemAck, iMemRData,
      output oCpuRData, oCpuReady, oBusy,
      output oMemReq, oMemWe, oMemAddr, oMemWData
   );

   modport master (
      output iCpuReq, iCpuWe, iCpuAddr, iCpuWData,
      output iFlush, iMemAck, iMemRData,
      input  oCpuRData, oCpuReady, oBusy,
      input  oMemReq, oMemWe, oMemAddr, oMemWData
   );

endinterface

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays of the cache: one write port, async read.
// Ports: iFlush clears all valid bits; iWe writes line iWIdx.
module cache_line_store
   import cache_pkg::*;
(
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iFlush,
   input  logic        iWe,
   input  idx_t        iWIdx,
   input  tag_t        iWTag,
   input  logic [31:0] iWData,
   input  idx_t        iRIdx,
   output logic        oValid,
   output tag_t        oTag,
   output logic [31:0] oData
);

   logic [LINES-1:0] r_valid;
   tag_t             r_tag  [LINES];
   logic [31:0]      r_data [LINES];

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_valid <= '0;
      end else if (iFlush) begin
         r_valid <= '0;
      end else if (iWe) begin
         r_valid[iWIdx] <= 1'b1;
      end
   end

   // Tag and data contents are meaningless until valid is set.
   always_ff @(posedge iClk) begin
      if (iWe) begin
         r_tag[iWIdx]  <= iWTag;
         r_data[iWIdx] <= iWData;
      end
   end

   assign oValid = r_valid[iRIdx];
   assign oTag   = r_tag[iRIdx];
   assign oData  = r_data[iRIdx];

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate direct-mapped cache sequencer.
// Ports: iClk, iRstN, bus (CPU request + memory side, slave view).
module cache_controller
   import cache_pkg::*;
(
   input logic               iClk,
   input logic               iRstN,
   cache_controller_if.slave bus
);

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   tag_t        r_tag;
   idx_t        r_idx;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic        w_valid;
   tag_t        w_ltag;
   logic [31:0] w_ldata;
   logic        w_hit;
   logic        w_flush;
   logic        w_accept;
   logic        w_lwe;
   logic [31:0] w_lwdata;
   logic        w_unused_off;

   // Word-aligned: byte offset bits carry no information.
   assign w_unused_off = ^bus.iCpuAddr[1:0];

   cache_line_store u_store (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iFlush (w_flush),
      .iWe    (w_lwe),
      .iWIdx  (r_idx),
      .iWTag  (r_tag),
      .iWData (w_lwdata),
      .iRIdx  (r_idx),
      .oValid (w_valid),
      .oTag   (w_ltag),
      .oData  (w_ldata)
   );

   assign w_hit    = w_valid && (w_ltag == r_tag);
   // Flush wins over a simultaneous request.
   assign w_flush  = (r_state == IDLE) && bus.iFlush;
   assign w_accept = (r_state == IDLE) && !bus.iFlush
                     && bus.iCpuReq;

   // One write port: store-hit update or read-miss fill.
   assign w_lwe = ((r_state == LOOKUP) && r_we && w_hit)
               || ((r_state == MEM_RD) && bus.iMemAck);
   assign w_lwdata = (r_state == MEM_RD) ? bus.iMemRData
                                         : r_wdata;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) w_next = LOOKUP;
         end
         LOOKUP: begin
            if (r_we)       w_next = MEM_WR;
            else if (w_hit) w_next = DONE;
            else            w_next = MEM_RD;
         end
         MEM_RD, MEM_WR: begin
            if (bus.iMemAck) w_next = DONE;
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_comb begin
      bus.oCpuReady = (r_state == DONE);
      bus.oBusy     = (r_state != IDLE);
      bus.oMemReq   = (r_state == MEM_RD)
                   || (r_state == MEM_WR);
      bus.oMemWe    = (r_state == MEM_WR);
      bus.oMemAddr  = mk_addr(r_tag, r_idx);
      bus.oMemWData = r_wdata;
      bus.oCpuRData = r_rdata;
   end

   // Request latch: later iCpu* changes are ignored until IDLE.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_we    <= 1'b0;
         r_tag   <= '0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_we    <= bus.iCpuWe;
         r_tag   <= addr_tag(bus.iCpuAddr);
         r_idx   <= addr_idx(bus.iCpuAddr);
         r_wdata <= bus.iCpuWData;
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_rdata <= '0;
      end else if ((r_state == LOOKUP) && !r_we && w_hit) begin
         r_rdata <= w_ldata;
      end else if ((r_state == MEM_RD) && bus.iMemAck) begin
         r_rdata <= bus.iMemRData;
      end
   end

endmodule
